lcd_mode_arbiter: RTL and testbench
===================================

// Module: lcd_mode_arbiter
// PURPOSE
//  Owns the shared 16x2 character-LCD bus (RW/RS/DATA) and grants it to one mode block at a time.
//  Mode blocks include the clock, time-set and similar screens; the grant follows the MODE select.
//  After reset it runs the LCD power-up init sequence.
//  On every mode change it clears the display and restarts the new owner's frame via EN.
//  It sits between the mode blocks and the top-level LCD pins.
// PARAMETERS
//  N_SRC     4   number of mode sources; source i owns the bus when MODE==i
//  PWR_WAIT  20  CLK cycles of idle after reset before the first init command (LCD power-on delay)
//  CLR_WAIT  2   idle CLK cycles after each clear-display command (0x01)
// PORTS
//  CLK       in   1        system clock; one LCD word is transferred per cycle
//  RESET     in   1        asynchronous, active-low
//  MODE      in   4        current mode select from the mode FSM
//  SRC_RW    in   N_SRC    RW from each source
//  SRC_RS    in   N_SRC    RS from each source
//  SRC_DATA  in   8*N_SRC  DATA from each source; source i occupies bits [8i+7:8i]
//  EN        out  1        frame enable to all sources; 0 forces their frame counter to 0
//  GRANT     out  N_SRC    one-hot owner indication; all zero when no source owns the bus
//  READY     out  1        1 once the init sequence has completed
//  LCD_RW    out  1        registered LCD RW
//  LCD_RS    out  1        registered LCD RS
//  LCD_DATA  out  8        registered LCD data
// BEHAVIOUR
//  Reset values:
//   - LCD_RW=1, LCD_RS=1, LCD_DATA=8'h02 (the IDLE word).
//   - EN=0, GRANT=0, READY=0.
//   - State PWR, wait counter=0.
//  Command word: RW=0, RS=0, DATA=code.
//  States:
//   - PWR: output IDLE, EN=0. Wait PWR_WAIT cycles, then go to INIT.
//   - INIT: issue one command per cycle: 8'h38 function set, 8'h0C display on, 8'h06 entry mode, 8'h01 clear.
//     Then go to CWAIT. EN=0 throughout.
//   - CWAIT: output IDLE, EN=0 for CLR_WAIT cycles.
//     On exit: READY=1, mode_q<=MODE, go to RUN.
//   - RUN:
//     - EN=1.
//     - If mode_q<N_SRC: GRANT[mode_q]=1 and LCD_* <= SRC_*[mode_q] registered, giving exactly 1 cycle latency.
//     - Otherwise: GRANT=0 and output IDLE.
//  Mode change:
//   - In RUN, MODE!=mode_q in cycle t means that in cycle t+1 EN=0, GRANT=0 and the clear command is driven.
//   - The block then passes through CWAIT (CLR_WAIT cycles) and re-enters RUN with mode_q updated.
//   - The new source therefore restarts its frame at count 0.
//   - No word from the new source reaches the bus before the clear.
//  MODE changes during PWR/INIT/CWAIT are not acted on immediately; they are sampled at CWAIT exit.
//  A MODE change during a switch's CWAIT: the latest value is taken at exit, with no second clear.
//  MODE toggling A->B->A within one cycle of RUN is still treated as one switch (compare is registered).
//  Reset asserted mid-frame or mid-init: all outputs return to reset values immediately.
//  After release, the full PWR+INIT sequence reruns.
//  Counters saturate at their terminal values; they never wrap.
//  READY never falls except on RESET.
// STRUCTURE
//  Shared package lcd_pkg:
//   - command codes CMD_FUNC=8'h38, CMD_DISP=8'h0C, CMD_ENTRY=8'h06, CMD_CLR=8'h01
//   - IDLE word {RW=1, RS=1, DATA=8'h02}
//   - DDRAM line addresses 8'h80 and 8'hC0
//   - state encoding
//  One sub-module: lcd_init_seq, containing the PWR/INIT/CWAIT counter, a 2-bit command index and a done pulse.
//  It is reused by the mode-switch path, started at the clear step.
//  The top level holds the RUN/SWITCH logic, the mode_q register and the N_SRC-way output mux.
// TESTING
//  1. Reset release, MODE=0: check the following, in order.
//     - IDLE for 20 cycles.
//     - Then 38,0C,06,01 with RS=0 on consecutive cycles.
//     - Then 2 IDLE cycles.
//     - Then READY=1, EN=1, GRANT=0001.
//  2. RUN with MODE=0, source 0 driving RS=1 DATA=8'h4D at cycle t: LCD_DATA=8'h4D, LCD_RS=1 at cycle t+1.
//  3. MODE 0->1 in RUN: check the following, in order.
//     - Next cycle EN=0, GRANT=0, DATA=01 RS=0.
//     - Then 2 IDLE cycles.
//     - Then EN=1, GRANT=0010.
//     - First word is source 1's 8'h80 command.
//  4. MODE=5 (>=N_SRC): GRANT=0, LCD_* stay 1/1/8'h02, EN=1.
//     Then MODE=2: one clear and grant to source 2.
//  5. MODE changed 0->3 during INIT: init completes unaltered, then GRANT=1000 with no extra clear.
//  6. RESET pulsed low while in RUN mid-frame: outputs go to IDLE and READY=0 asynchronously.
//     After release, test 1's sequence repeats exactly.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD bus: command codes, the idle bus
// word, DDRAM line addresses and the init/arbitration state encoding.
package lcd_pkg;

    // HD44780-style command codes used by the power-up sequence and mode switches
    localparam logic [7:0] CMD_FUNC  = 8'h38;   // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISP  = 8'h0C;   // display on, cursor off
    localparam logic [7:0] CMD_ENTRY = 8'h06;   // increment, no shift
    localparam logic [7:0] CMD_CLR   = 8'h01;   // clear display, home cursor

    // DDRAM set-address commands for the start of each display line
    localparam logic [7:0] DDRAM_LINE1 = 8'h80;
    localparam logic [7:0] DDRAM_LINE2 = 8'hC0;

    // One word on the shared LCD bus
    typedef struct packed {
        logic       rw;
        logic       rs;
        logic [7:0] data;
    } lcd_word_t;

    // Word parked on the bus whenever nobody is talking to the panel
    localparam lcd_word_t IDLE_WORD = '{rw: 1'b1, rs: 1'b1, data: 8'h02};

    // PWR: power-on delay, INIT: command burst, CWAIT: post-clear delay,
    // RUN: bus handed to the selected mode source
    typedef enum logic [1:0] {
        ST_PWR,
        ST_INIT,
        ST_CWAIT,
        ST_RUN
    } seq_state_t;

    // A command is always written with RW=0, RS=0
    function automatic lcd_word_t cmd_word(input logic [7:0] code);
        cmd_word = '{rw: 1'b0, rs: 1'b0, data: code};
    endfunction

    // Command issued at each step of the power-up burst; the last one is the clear
    function automatic logic [7:0] init_code(input logic [1:0] idx);
        case (idx)
            2'd0:    init_code = CMD_FUNC;
            2'd1:    init_code = CMD_DISP;
            2'd2:    init_code = CMD_ENTRY;
            default: init_code = CMD_CLR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_init_seq.sv
// LCD power-up sequencer: waits PWR_WAIT cycles, walks the four init commands,
// then holds CWAIT for CLR_WAIT cycles before handing over to RUN. From RUN it
// can be restarted at the post-clear wait, which is how a mode switch reuses it.
// Both wait parameters must be at least 1.
module lcd_init_seq
    import lcd_pkg::*;
#(
    parameter int PWR_WAIT = 20,
    parameter int CLR_WAIT = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       i_start,     // in RUN: clear was just issued, begin CWAIT
    output seq_state_t o_state,
    output lcd_word_t  o_cmd,       // command for the current INIT step
    output logic       o_done       // last CWAIT cycle; RUN follows next cycle
);

    localparam int MAX_WAIT = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_WAIT - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_WAIT - 1);

    seq_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;

    // Sequencer state, shared wait counter and command index.
    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_PWR;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_PWR: begin
                    if (r_cnt == PWR_LAST) begin
                        r_state <= ST_INIT;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_INIT: begin
                    if (r_idx == 2'd3) begin
                        r_state <= ST_CWAIT;
                        r_cnt   <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_CWAIT: begin
                    // counter holds at its terminal value on the way out
                    if (r_cnt == CLR_LAST) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (i_start) begin
                        r_state <= ST_CWAIT;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= ST_PWR;
            endcase
        end
    end

    assign o_state = r_state;
    assign o_cmd   = cmd_word(init_code(r_idx));
    assign o_done  = (r_state == ST_CWAIT) && (r_cnt == CLR_LAST);

endmodule

// File: rtl/lcd_mode_arbiter.sv
// Owner of the shared 16x2 LCD bus. Runs the power-up sequence after reset,
// then grants the bus to the mode source selected by MODE. Any change of MODE
// while running issues a clear, drops EN so the new owner restarts its frame,
// and re-enters RUN after the post-clear wait with the latest MODE.
module lcd_mode_arbiter
    import lcd_pkg::*;
#(
    parameter int N_SRC    = 4,
    parameter int PWR_WAIT = 20,
    parameter int CLR_WAIT = 2
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [3:0]           MODE,
    input  logic [N_SRC-1:0]     SRC_RW,
    input  logic [N_SRC-1:0]     SRC_RS,
    input  logic [8*N_SRC-1:0]   SRC_DATA,
    output logic                 EN,
    output logic [N_SRC-1:0]     GRANT,
    output logic                 READY,
    output logic                 LCD_RW,
    output logic                 LCD_RS,
    output logic [7:0]           LCD_DATA
);

    seq_state_t       w_seq_state;
    lcd_word_t        w_init_cmd;
    logic             w_seq_done;
    logic             w_switch;
    lcd_word_t        w_src_word;
    logic [N_SRC-1:0] w_src_grant;

    lcd_word_t        r_word;
    logic             r_en;
    logic [N_SRC-1:0] r_grant;
    logic             r_ready;
    logic [3:0]       r_mode_q;

    lcd_init_seq #(
        .PWR_WAIT (PWR_WAIT),
        .CLR_WAIT (CLR_WAIT)
    ) u_init_seq (
        .CLK     (CLK),
        .RESET   (RESET),
        .i_start (w_switch),
        .o_state (w_seq_state),
        .o_cmd   (w_init_cmd),
        .o_done  (w_seq_done)
    );

    // A registered owner that differs from the live MODE triggers a switch
    assign w_switch = (w_seq_state == ST_RUN) && (MODE != r_mode_q);

    // Select the owning source's word and its one-hot grant; out-of-range owners get IDLE.
    // NOTE: every output gets a default before the loop, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        w_src_word  = IDLE_WORD;
        w_src_grant = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_mode_q == 4'(i)) begin
                w_src_word     = '{rw: SRC_RW[i], rs: SRC_RS[i], data: SRC_DATA[8*i +: 8]};
                w_src_grant[i] = 1'b1;
            end
        end
    end

    // Registered bus outputs, frame enable, grant, ready flag and owner register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_word   <= IDLE_WORD;
            r_en     <= 1'b0;
            r_grant  <= '0;
            r_ready  <= 1'b0;
            r_mode_q <= '0;
        end else begin
            // the owner is chosen from the latest MODE as the post-clear wait ends
            if (w_seq_done) begin
                r_mode_q <= MODE;
            end
            case (w_seq_state)
                ST_RUN: begin
                    if (w_switch) begin
                        r_word  <= cmd_word(CMD_CLR);
                        r_en    <= 1'b0;
                        r_grant <= '0;
                    end else begin
                        r_word  <= w_src_word;
                        r_en    <= 1'b1;
                        r_grant <= w_src_grant;
                        r_ready <= 1'b1;
                    end
                end
                ST_INIT: begin
                    r_word  <= w_init_cmd;
                    r_en    <= 1'b0;
                    r_grant <= '0;
                end
                default: begin
                    r_word  <= IDLE_WORD;
                    r_en    <= 1'b0;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign LCD_RW   = r_word.rw;
    assign LCD_RS   = r_word.rs;
    assign LCD_DATA = r_word.data;
    assign EN       = r_en;
    assign GRANT    = r_grant;
    assign READY    = r_ready;

endmodule

// File: tb/tb_lcd_mode_arbiter.sv
// Scoreboard bench for lcd_mode_arbiter. Stimulus pushes the expected
// {rw,rs,data,en,grant,ready} for every clock; a monitor pops and compares
// one entry shortly after each rising edge.
module tb_lcd_mode_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  MODE;
    logic [3:0]  SRC_RW;
    logic [3:0]  SRC_RS;
    logic [31:0] SRC_DATA;
    logic        EN;
    logic [3:0]  GRANT;
    logic        READY;
    logic        LCD_RW;
    logic        LCD_RS;
    logic [7:0]  LCD_DATA;

    lcd_mode_arbiter #(
        .N_SRC    (4),
        .PWR_WAIT (20),
        .CLR_WAIT (2)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .MODE     (MODE),
        .SRC_RW   (SRC_RW),
        .SRC_RS   (SRC_RS),
        .SRC_DATA (SRC_DATA),
        .EN       (EN),
        .GRANT    (GRANT),
        .READY    (READY),
        .LCD_RW   (LCD_RW),
        .LCD_RS   (LCD_RS),
        .LCD_DATA (LCD_DATA)
    );

    always #5 CLK = ~CLK;

    // bus words as {rw, rs, data}
    localparam logic [9:0] W_IDLE = {1'b1, 1'b1, 8'h02};
    localparam logic [9:0] W_CLR  = {1'b0, 1'b0, 8'h01};

    int n_tests = 0;
    int n_fail  = 0;
    int n_push  = 0;
    int n_pop   = 0;

    logic [15:0] exp_q[$];
    string       name_q[$];

    logic [15:0] w_outs;
    assign w_outs = {LCD_RW, LCD_RS, LCD_DATA, EN, GRANT, READY};

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h  ({rw,rs,data,en,grant,ready})", nm, got, exp);
        end
    endtask

    function automatic logic [15:0] wx(input logic [9:0] w, input logic en,
                                       input logic [3:0] g, input logic rdy);
        return {w, en, g, rdy};
    endfunction

    // push one expectation for the coming rising edge, then move to the next falling edge
    task automatic step(input string nm, input logic [15:0] e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        n_push++;
        @(negedge CLK);
    endtask

    task automatic set_src(input int i, input logic rw, input logic rs, input logic [7:0] d);
        SRC_RW[i]         = rw;
        SRC_RS[i]         = rs;
        SRC_DATA[8*i +: 8] = d;
    endtask

    // monitor: compare the DUT outputs 1 time unit after each rising edge
    initial begin
        logic [15:0] e;
        string       nm;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_pop++;
                check(nm, 32'(w_outs), 32'(e));
            end
        end
    end

    // full power-up: 20 IDLE, 4 commands, 2 IDLE, then the first RUN word
    task automatic init_seq(input string tag, input logic [3:0] mode_mid,
                            input logic [3:0] g_exp, input logic [9:0] w_exp);
        logic [7:0] codes [4];
        codes[0] = 8'h38; codes[1] = 8'h0C; codes[2] = 8'h06; codes[3] = 8'h01;
        for (int i = 0; i < 20; i++)
            step($sformatf("%s_pwr%0d", tag, i), wx(W_IDLE, 1'b0, 4'b0000, 1'b0));
        MODE = mode_mid;
        for (int i = 0; i < 4; i++)
            step($sformatf("%s_cmd%0d", tag, i), wx({2'b00, codes[i]}, 1'b0, 4'b0000, 1'b0));
        for (int i = 0; i < 2; i++)
            step($sformatf("%s_cwait%0d", tag, i), wx(W_IDLE, 1'b0, 4'b0000, 1'b0));
        step($sformatf("%s_run", tag), wx(w_exp, 1'b1, g_exp, 1'b1));
    endtask

    // mode change from RUN: clear, two IDLE, then the new owner's word
    task automatic switch_to(input string tag, input logic [3:0] new_mode,
                             input logic [3:0] g_exp, input logic [9:0] w_exp);
        MODE = new_mode;
        step($sformatf("%s_clr", tag), wx(W_CLR, 1'b0, 4'b0000, 1'b1));
        step($sformatf("%s_cw0", tag), wx(W_IDLE, 1'b0, 4'b0000, 1'b1));
        step($sformatf("%s_cw1", tag), wx(W_IDLE, 1'b0, 4'b0000, 1'b1));
        step($sformatf("%s_run", tag), wx(w_exp, 1'b1, g_exp, 1'b1));
    endtask

    // asynchronous reset mid-cycle: outputs must drop before any clock edge
    task automatic pulse_reset(input string tag);
        #2;
        RESET = 1'b0;
        #1;
        check($sformatf("%s_async_reset", tag), 32'(w_outs), 32'(wx(W_IDLE, 1'b0, 4'b0000, 1'b0)));
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    // watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        MODE     = 4'd0;
        SRC_RW   = '0;
        SRC_RS   = '0;
        SRC_DATA = '0;
        set_src(0, 1'b0, 1'b1, 8'h41);
        set_src(1, 1'b0, 1'b0, 8'h80);
        set_src(2, 1'b0, 1'b1, 8'h52);
        set_src(3, 1'b0, 1'b1, 8'h33);

        // reset state
        RESET = 1'b1;
        #2;
        RESET = 1'b0;
        #1;
        check("reset_state", 32'(w_outs), 32'(wx(W_IDLE, 1'b0, 4'b0000, 1'b0)));
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;

        // 1: power-up with MODE=0
        init_seq("t1", 4'd0, 4'b0001, {1'b0, 1'b1, 8'h41});

        // 2: one-cycle pass-through from source 0, other sources ignored
        set_src(0, 1'b0, 1'b1, 8'h4D);
        step("t2_4d", wx({1'b0, 1'b1, 8'h4D}, 1'b1, 4'b0001, 1'b1));
        set_src(0, 1'b1, 1'b0, 8'hA5);
        set_src(1, 1'b1, 1'b1, 8'hFF);
        step("t2_a5", wx({1'b1, 1'b0, 8'hA5}, 1'b1, 4'b0001, 1'b1));
        set_src(0, 1'b0, 1'b0, 8'hC0);
        step("t2_c0", wx({1'b0, 1'b0, 8'hC0}, 1'b1, 4'b0001, 1'b1));

        // 3: switch 0 -> 1, first word is source 1's line-1 address command
        set_src(1, 1'b0, 1'b0, 8'h80);
        switch_to("t3", 4'd1, 4'b0010, {1'b0, 1'b0, 8'h80});
        set_src(1, 1'b0, 1'b1, 8'h48);
        step("t3_next", wx({1'b0, 1'b1, 8'h48}, 1'b1, 4'b0010, 1'b1));

        // 4: out-of-range mode parks the bus at IDLE with EN=1, then mode 2
        switch_to("t4_m5", 4'd5, 4'b0000, W_IDLE);
        set_src(0, 1'b0, 1'b0, 8'h11);
        step("t4_m5_hold0", wx(W_IDLE, 1'b1, 4'b0000, 1'b1));
        set_src(1, 1'b0, 1'b0, 8'h22);
        step("t4_m5_hold1", wx(W_IDLE, 1'b1, 4'b0000, 1'b1));
        switch_to("t4_m2", 4'd2, 4'b0100, {1'b0, 1'b1, 8'h52});
        set_src(2, 1'b0, 1'b1, 8'h6F);
        step("t4_m2_next", wx({1'b0, 1'b1, 8'h6F}, 1'b1, 4'b0100, 1'b1));

        // 6: reset mid-frame, then the full power-up repeats exactly
        pulse_reset("t6");
        MODE = 4'd0;
        set_src(0, 1'b0, 1'b1, 8'h41);
        init_seq("t6", 4'd0, 4'b0001, {1'b0, 1'b1, 8'h41});

        // 5: MODE moves 0 -> 3 during INIT; no extra clear afterwards
        pulse_reset("t5");
        MODE = 4'd0;
        set_src(3, 1'b0, 1'b0, 8'hC0);
        init_seq("t5", 4'd3, 4'b1000, {1'b0, 1'b0, 8'hC0});
        set_src(3, 1'b0, 1'b1, 8'h21);
        step("t5_run1", wx({1'b0, 1'b1, 8'h21}, 1'b1, 4'b1000, 1'b1));
        step("t5_run2", wx({1'b0, 1'b1, 8'h21}, 1'b1, 4'b1000, 1'b1));

        // MODE 3 -> 0 -> 3 across one switch: single clear, owner stays 3
        MODE = 4'd0;
        step("tog_clr", wx(W_CLR, 1'b0, 4'b0000, 1'b1));
        MODE = 4'd3;
        step("tog_cw0", wx(W_IDLE, 1'b0, 4'b0000, 1'b1));
        step("tog_cw1", wx(W_IDLE, 1'b0, 4'b0000, 1'b1));
        step("tog_run", wx({1'b0, 1'b1, 8'h21}, 1'b1, 4'b1000, 1'b1));
        step("tog_run2", wx({1'b0, 1'b1, 8'h21}, 1'b1, 4'b1000, 1'b1));

        // every pushed expectation must have been consumed by the monitor
        @(negedge CLK);
        check("scoreboard_drained", 32'(n_pop), 32'(n_push));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
